// File: rtl/rw_mode_scheduler.sv
// rw_mode_scheduler
// Chooses, cycle by cycle, whether the shared back-end command path serves
// reads or writes.  It keeps pending read/write counts and applies
// write-drain watermarks, a bus-turnaround gap and a write-burst cap.
module rw_mode_scheduler #(
   parameter int DEPTH        = 64,
   parameter int CNT_W        = 7,
   parameter int WR_HIGH      = 48,
   parameter int WR_LOW       = 16,
   parameter int TURN         = 2,
   parameter int MAX_WR_BURST = 32
) (
   input  logic             clk,
   input  logic             rst_n,      // asynchronous, active-high despite the name
   input  logic             rd_push,
   input  logic             wr_push,
   input  logic             grant_i,
   output logic             issue_rd,
   output logic             issue_wr,
   output logic             mode,
   output logic             turning,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] wr_cnt,
   output logic             rd_full,
   output logic             wr_full,
   output logic             overflow
);

   localparam int TURN_W  = (TURN > 1) ? $clog2(TURN) : 1;
   localparam int BURST_W = $clog2(MAX_WR_BURST + 1);

   localparam logic [CNT_W-1:0]   L_DEPTH     = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]   L_WR_HIGH   = CNT_W'(WR_HIGH);
   localparam logic [CNT_W-1:0]   L_WR_LOW    = CNT_W'(WR_LOW);
   localparam logic [CNT_W-1:0]   L_CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [TURN_W-1:0]  L_TURN_M1   = TURN_W'(TURN - 1);
   localparam logic [TURN_W-1:0]  L_TURN_ZERO = {TURN_W{1'b0}};
   localparam logic [BURST_W-1:0] L_MAX_BURST = BURST_W'(MAX_WR_BURST);
   localparam logic [BURST_W-1:0] L_BURST_Z   = {BURST_W{1'b0}};

   typedef enum logic [1:0] {
      ST_READ     = 2'd0,
      ST_TO_WRITE = 2'd1,
      ST_WRITE    = 2'd2,
      ST_TO_READ  = 2'd3
   } state_t;

   state_t             r_state;
   logic [TURN_W-1:0]  r_turn_cnt;
   logic [BURST_W-1:0] r_wr_burst;
   logic [CNT_W-1:0]   r_rd_cnt;
   logic [CNT_W-1:0]   r_wr_cnt;
   logic               r_overflow;

   state_t             w_state_nxt;
   logic [TURN_W-1:0]  w_turn_nxt;
   logic [BURST_W-1:0] w_burst_nxt;
   logic [CNT_W-1:0]   w_rd_cnt_nxt;
   logic [CNT_W-1:0]   w_wr_cnt_nxt;
   logic               w_rd_pend;
   logic               w_wr_pend;
   logic               w_rd_full;
   logic               w_wr_full;
   logic               w_leave_write;
   logic               w_issue_rd;
   logic               w_issue_wr;

   // Pending count after one push and one issue; a push into a full buffer is dropped.
   function automatic logic [CNT_W-1:0] cnt_next(
      input logic [CNT_W-1:0] cnt,
      input logic             push,
      input logic             full,
      input logic             issue
   );
      logic [CNT_W-1:0] v;
      v = cnt;
      if (push && !full) begin
         v = v + CNT_W'(1);
      end else begin
         v = v;
      end
      if (issue) begin
         v = v - CNT_W'(1);
      end else begin
         v = v;
      end
      return v;
   endfunction

   assign w_rd_pend = (r_rd_cnt != L_CNT_ZERO);
   assign w_wr_pend = (r_wr_cnt != L_CNT_ZERO);
   assign w_rd_full = (r_rd_cnt == L_DEPTH);
   assign w_wr_full = (r_wr_cnt == L_DEPTH);

   // Write mode gives way to pending reads at the low watermark, when empty,
   // or once the burst cap is reached.
   assign w_leave_write = (r_state == ST_WRITE) && w_rd_pend &&
                          ((r_wr_cnt <= L_WR_LOW) || !w_wr_pend ||
                           (r_wr_burst == L_MAX_BURST));

   // The cycle that decides to leave write mode dispatches nothing, so the
   // burst cap is a hard limit and the drain stops exactly at the watermark.
   assign w_issue_rd = (r_state == ST_READ) && w_rd_pend && grant_i;
   assign w_issue_wr = (r_state == ST_WRITE) && w_wr_pend && grant_i && !w_leave_write;

   assign w_rd_cnt_nxt = cnt_next(r_rd_cnt, rd_push, w_rd_full, w_issue_rd);
   assign w_wr_cnt_nxt = cnt_next(r_wr_cnt, wr_push, w_wr_full, w_issue_wr);

   // Next-state, turnaround countdown and write-burst tracking.
   always_comb begin
      w_state_nxt = r_state;
      w_turn_nxt  = r_turn_cnt;
      w_burst_nxt = r_wr_burst;
      case (r_state)
         ST_READ: begin
            if ((r_wr_cnt >= L_WR_HIGH) || (!w_rd_pend && w_wr_pend)) begin
               w_state_nxt = ST_TO_WRITE;
               w_turn_nxt  = L_TURN_M1;
            end else begin
               w_state_nxt = ST_READ;
            end
         end
         ST_TO_WRITE: begin
            if (r_turn_cnt == L_TURN_ZERO) begin
               w_state_nxt = ST_WRITE;
               w_burst_nxt = L_BURST_Z;
            end else begin
               w_turn_nxt = r_turn_cnt - TURN_W'(1);
            end
         end
         ST_WRITE: begin
            if (w_leave_write) begin
               w_state_nxt = ST_TO_READ;
               w_turn_nxt  = L_TURN_M1;
            end else if (w_issue_wr && (r_wr_burst != L_MAX_BURST)) begin
               w_burst_nxt = r_wr_burst + BURST_W'(1);
            end else begin
               w_burst_nxt = r_wr_burst;
            end
         end
         ST_TO_READ: begin
            if (r_turn_cnt == L_TURN_ZERO) begin
               w_state_nxt = ST_READ;
            end else begin
               w_turn_nxt = r_turn_cnt - TURN_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_READ;
            w_turn_nxt  = L_TURN_ZERO;
            w_burst_nxt = L_BURST_Z;
         end
      endcase
   end

   // State, counters and sticky overflow register.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state    <= ST_READ;
         r_turn_cnt <= L_TURN_ZERO;
         r_wr_burst <= L_BURST_Z;
         r_rd_cnt   <= L_CNT_ZERO;
         r_wr_cnt   <= L_CNT_ZERO;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_turn_cnt <= w_turn_nxt;
         r_wr_burst <= w_burst_nxt;
         r_rd_cnt   <= w_rd_cnt_nxt;
         r_wr_cnt   <= w_wr_cnt_nxt;
         r_overflow <= r_overflow | (rd_push & w_rd_full) | (wr_push & w_wr_full);
      end
   end

   assign issue_rd = w_issue_rd;
   assign issue_wr = w_issue_wr;
   assign mode     = (r_state == ST_TO_WRITE) || (r_state == ST_WRITE);
   assign turning  = (r_state == ST_TO_WRITE) || (r_state == ST_TO_READ);
   assign rd_cnt   = r_rd_cnt;
   assign wr_cnt   = r_wr_cnt;
   assign rd_full  = w_rd_full;
   assign wr_full  = w_wr_full;
   assign overflow = r_overflow;

endmodule
